// File: rtl/uart_pkg.sv
//==============================================================================
// Module      : uart_pkg
// Description : Definitions shared by the UART transmit and receive paths:
//               FSM state encoding, parity-mode constants and the bit-period
//               divisor derivation.
// Revision    : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package uart_pkg;

    // Frame sequencing states, shared with the receive path.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Parity modes.
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Clock cycles per bit. The result is truncated, so the line rate is
    // slightly fast when CLK_FREQ is not an exact multiple of BAUD_RATE.
    function automatic int calc_bps_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tx_bps_module.sv
//==============================================================================
// Module      : tx_bps_module
// Description : Bit-period counter for the UART transmitter. Counts
//               0..BPS_DIV-1 while Count_Sig is high, then wraps. BPS_CLK is
//               high for the single cycle in which the counter wraps.
//               The counter is held at 0 while Count_Sig is low.
// Ports       : CLK       in  system clock
//               RST       in  synchronous reset, active-high
//               Count_Sig in  enable; low clears and holds the counter
//               BPS_CLK   out one-cycle pulse at the end of each bit period
// Revision    : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tx_bps_module #(
    parameter int BPS_DIV = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic Count_Sig,
    output logic BPS_CLK
);

    localparam int                 c_cnt_w   = (BPS_DIV > 1) ? $clog2(BPS_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(BPS_DIV - 1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge CLK) begin
        if (RST || !Count_Sig) begin
            r_count <= '0;
        end else if (r_count == c_cnt_max) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // Decoded from the counter register, so the pulse lines up with the
    // edge on which the counter returns to 0.
    assign BPS_CLK = Count_Sig && (r_count == c_cnt_max);

endmodule

`default_nettype wire

// File: rtl/tx_control_module.sv
//==============================================================================
// Module      : tx_control_module
// Description : UART transmit engine. Accepts one byte per handshake and
//               sends it LSB-first as start, 8 data, optional parity and
//               1 or 2 stop bits. Bit timing comes from tx_bps_module.
// Ports       : CLK         in  system clock
//               RST         in  synchronous reset, active-high
//               TX_En_Sig   in  send request, honoured only while TX_Ready=1
//               TX_Data     in  byte to send, sampled in the accept cycle
//               TX_Ready    out idle and able to accept a request
//               TX_Done_Sig out one-cycle pulse after the final stop bit
//               TX_Pin_Out  out registered serial line, idle high
// Revision    : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tx_control_module
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TX_En_Sig,
    input  logic [7:0] TX_Data,
    output logic       TX_Ready,
    output logic       TX_Done_Sig,
    output logic       TX_Pin_Out
);

    localparam int   c_bps_div   = calc_bps_div(CLK_FREQ, BAUD_RATE);
    // Value of the stop counter during the final stop period.
    localparam logic c_last_stop = (STOP_BITS == 2);

    uart_state_e r_state,    w_state_nx;
    logic [7:0]  r_shift,    w_shift_nx;
    logic        r_parity,   w_parity_nx;
    logic [2:0]  r_bit_idx,  w_bit_idx_nx;
    logic        r_stop_cnt, w_stop_cnt_nx;
    logic        r_tx,       w_tx_nx;
    logic        r_ready,    w_ready_nx;
    logic        r_done,     w_done_nx;

    logic        w_count_sig;
    logic        w_bps_clk;
    logic        w_par_bit;

    // The timer runs only while a frame is in flight; in IDLE it is held at
    // 0, which gives every accepted frame a fresh bit period.
    assign w_count_sig = (r_state != ST_IDLE);

    tx_bps_module #(
        .BPS_DIV (c_bps_div)
    ) u_tx_bps (
        .CLK       (CLK),
        .RST       (RST),
        .Count_Sig (w_count_sig),
        .BPS_CLK   (w_bps_clk)
    );

    // Odd parity makes the total number of ones odd, so it is the
    // complement of the XOR reduction.
    assign w_par_bit = (PARITY == PARITY_ODD) ? ~^TX_Data : ^TX_Data;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_shift    <= w_shift_nx;
            r_parity   <= w_parity_nx;
            r_bit_idx  <= w_bit_idx_nx;
            r_stop_cnt <= w_stop_cnt_nx;
            r_tx       <= w_tx_nx;
            r_ready    <= w_ready_nx;
            r_done     <= w_done_nx;
        end
    end

    // Next-state logic. Each branch computes the value the line will carry
    // during the next bit, so TX_Pin_Out changes on the same edge as the
    // state and stays glitch-free.
    always_comb begin
        w_state_nx    = r_state;
        w_shift_nx    = r_shift;
        w_parity_nx   = r_parity;
        w_bit_idx_nx  = r_bit_idx;
        w_stop_cnt_nx = r_stop_cnt;
        w_tx_nx       = r_tx;
        w_ready_nx    = r_ready;
        w_done_nx     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_tx_nx    = 1'b1;
                w_ready_nx = 1'b1;
                if (r_ready && TX_En_Sig) begin
                    w_shift_nx    = TX_Data;
                    w_parity_nx   = w_par_bit;
                    w_bit_idx_nx  = '0;
                    w_stop_cnt_nx = 1'b0;
                    w_state_nx    = ST_START;
                    w_tx_nx       = 1'b0;
                    w_ready_nx    = 1'b0;
                end
            end

            ST_START: begin
                if (w_bps_clk) begin
                    w_state_nx   = ST_DATA;
                    w_bit_idx_nx = '0;
                    w_tx_nx      = r_shift[0];
                    w_shift_nx   = {1'b0, r_shift[7:1]};
                end
            end

            ST_DATA: begin
                if (w_bps_clk) begin
                    if (r_bit_idx == 3'd7) begin
                        if (PARITY != PARITY_NONE) begin
                            w_state_nx = ST_PARITY;
                            w_tx_nx    = r_parity;
                        end else begin
                            w_state_nx    = ST_STOP;
                            w_stop_cnt_nx = 1'b0;
                            w_tx_nx       = 1'b1;
                        end
                    end else begin
                        w_bit_idx_nx = r_bit_idx + 3'd1;
                        w_tx_nx      = r_shift[0];
                        w_shift_nx   = {1'b0, r_shift[7:1]};
                    end
                end
            end

            ST_PARITY: begin
                if (w_bps_clk) begin
                    w_state_nx    = ST_STOP;
                    w_stop_cnt_nx = 1'b0;
                    w_tx_nx       = 1'b1;
                end
            end

            ST_STOP: begin
                w_tx_nx = 1'b1;
                if (w_bps_clk) begin
                    if (r_stop_cnt == c_last_stop) begin
                        // Ready rises with Done so a request in the Done
                        // cycle starts the next frame immediately.
                        w_state_nx = ST_IDLE;
                        w_done_nx  = 1'b1;
                        w_ready_nx = 1'b1;
                    end else begin
                        w_stop_cnt_nx = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nx = ST_IDLE;
                w_tx_nx    = 1'b1;
                w_ready_nx = 1'b1;
            end
        endcase
    end

    assign TX_Ready    = r_ready;
    assign TX_Done_Sig = r_done;
    assign TX_Pin_Out  = r_tx;

endmodule

`default_nettype wire

// File: tb/tb_tx_control_module.sv
`timescale 1ns/1ps
`default_nettype none

module tb_tx_control_module;

    // Four configurations share one stimulus bus:
    //   0: no parity, 1 stop   1: odd parity, 1 stop
    //   2: even parity, 1 stop 3: no parity, 2 stop
    logic       CLK = 1'b0;
    logic       RST;
    logic       TX_En_Sig;
    logic [7:0] TX_Data;
    logic [3:0] w_ready;
    logic [3:0] w_done;
    logic [3:0] w_pin;

    always #5 CLK = ~CLK;

    tx_control_module #(.CLK_FREQ(160), .BAUD_RATE(10), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .CLK(CLK), .RST(RST), .TX_En_Sig(TX_En_Sig), .TX_Data(TX_Data),
        .TX_Ready(w_ready[0]), .TX_Done_Sig(w_done[0]), .TX_Pin_Out(w_pin[0]));
    tx_control_module #(.CLK_FREQ(160), .BAUD_RATE(10), .PARITY(1), .STOP_BITS(1)) u_dut1 (
        .CLK(CLK), .RST(RST), .TX_En_Sig(TX_En_Sig), .TX_Data(TX_Data),
        .TX_Ready(w_ready[1]), .TX_Done_Sig(w_done[1]), .TX_Pin_Out(w_pin[1]));
    tx_control_module #(.CLK_FREQ(160), .BAUD_RATE(10), .PARITY(2), .STOP_BITS(1)) u_dut2 (
        .CLK(CLK), .RST(RST), .TX_En_Sig(TX_En_Sig), .TX_Data(TX_Data),
        .TX_Ready(w_ready[2]), .TX_Done_Sig(w_done[2]), .TX_Pin_Out(w_pin[2]));
    tx_control_module #(.CLK_FREQ(160), .BAUD_RATE(10), .PARITY(0), .STOP_BITS(2)) u_dut3 (
        .CLK(CLK), .RST(RST), .TX_En_Sig(TX_En_Sig), .TX_Data(TX_Data),
        .TX_Ready(w_ready[3]), .TX_Done_Sig(w_done[3]), .TX_Pin_Out(w_pin[3]));

    typedef struct {
        logic [1:0] cfg;
        logic [7:0] data;
        logic       exp_par;   // hand-computed parity bit (unused without parity)
        int         exp_len;   // hand-computed frame length in bit periods
        string      name;
    } vec_t;

    vec_t vecs [8];

    int n_checks = 0;
    int n_errors = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Compares {line, ready, done} of one configuration.
    task automatic check_idle(input string name, input logic [1:0] cfg, input logic [2:0] exp);
        logic [2:0] got;
        got = {w_pin[cfg], w_ready[cfg], w_done[cfg]};
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: {line,ready,done} got %b expected %b", name, got, exp);
        end
    endtask

    task automatic do_reset();
        RST       = 1'b1;
        TX_En_Sig = 1'b0;
        TX_Data   = 8'h00;
        tick();
        RST = 1'b0;
    endtask

    // Called #1 after the accept edge. Checks every cycle of the frame
    // (one comparison per bit period), decodes the data bits at mid-bit like
    // a receiver would, and finishes in the cycle where Done must be high.
    // mode 1 scrambles TX_En_Sig/TX_Data throughout, releasing the request
    // before the Done cycle.
    task automatic check_frame(input logic [1:0] cfg, input logic [7:0] exp_data,
                               input logic exp_par, input int nlen, input int mode,
                               input string name);
        logic [11:0] frame;
        logic [7:0]  dec;
        logic        eb;
        logic        bad;
        logic [2:0]  first_got;
        dec = 8'h00;
        if (cfg == 2'd1 || cfg == 2'd2) frame = {2'b11, exp_par, exp_data, 1'b0};
        else                            frame = {3'b111, exp_data, 1'b0};
        for (int b = 0; b < nlen; b++) begin
            eb        = frame[0];
            frame     = frame >> 1;
            bad       = 1'b0;
            first_got = 3'b000;
            for (int c = 0; c < 16; c++) begin
                if (!bad && (w_pin[cfg] !== eb || w_ready[cfg] !== 1'b0 || w_done[cfg] !== 1'b0)) begin
                    bad       = 1'b1;
                    first_got = {w_pin[cfg], w_ready[cfg], w_done[cfg]};
                end
                if (c == 8 && b >= 1 && b <= 8) dec = {w_pin[cfg], dec[7:1]};
                if (mode == 1) begin
                    if (b == nlen - 1 && c == 15) begin
                        TX_En_Sig = 1'b0;
                    end else begin
                        TX_En_Sig = 1'($urandom_range(0, 1));
                        TX_Data   = 8'($urandom);
                    end
                end
                tick();
            end
            n_checks++;
            if (bad) begin
                n_errors++;
                $display("FAIL %s bit%0d: {line,ready,done} got %b expected %b for all 16 cycles",
                         name, b, first_got, {eb, 2'b00});
            end
        end
        n_checks++;
        if (dec !== exp_data) begin
            n_errors++;
            $display("FAIL %s decode: got %02h expected %02h", name, dec, exp_data);
        end
        check_idle({name, "_done"}, cfg, 3'b111);
    endtask

    initial begin
        vecs[0] = '{2'd0, 8'h55, 1'b0, 10, "p0_55"};
        vecs[1] = '{2'd1, 8'hA3, 1'b1, 11, "odd_A3"};
        vecs[2] = '{2'd2, 8'hA3, 1'b0, 11, "even_A3"};
        vecs[3] = '{2'd3, 8'h00, 1'b0, 11, "stop2_00"};
        vecs[4] = '{2'd0, 8'hFF, 1'b0, 10, "p0_FF"};
        vecs[5] = '{2'd1, 8'h00, 1'b1, 11, "odd_00"};
        vecs[6] = '{2'd2, 8'h01, 1'b1, 11, "even_01"};
        vecs[7] = '{2'd3, 8'h6E, 1'b0, 11, "stop2_6E"};

        // Reset state of every configuration, and staying idle without a request.
        do_reset();
        for (int i = 0; i < 4; i++) check_idle("reset", 2'(i), 3'b110);
        repeat (20) tick();
        for (int i = 0; i < 4; i++) check_idle("idle_hold", 2'(i), 3'b110);

        // Table-driven single frames; Done must last exactly one cycle.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            TX_En_Sig = 1'b1;
            TX_Data   = vecs[v].data;
            tick();
            TX_En_Sig = 1'b0;
            check_frame(vecs[v].cfg, vecs[v].data, vecs[v].exp_par, vecs[v].exp_len, 0, vecs[v].name);
            tick();
            check_idle({vecs[v].name, "_after"}, vecs[v].cfg, 3'b110);
        end

        // Back-to-back: request held high, second start bit one cycle after Done.
        do_reset();
        TX_En_Sig = 1'b1;
        TX_Data   = 8'h01;
        tick();
        TX_Data = 8'h80;
        check_frame(2'd0, 8'h01, 1'b0, 10, 0, "b2b_first");
        tick();
        TX_En_Sig = 1'b0;
        check_frame(2'd0, 8'h80, 1'b0, 10, 0, "b2b_second");
        tick();
        check_idle("b2b_after", 2'd0, 3'b110);

        // Reset mid-frame: frame abandoned, no Done pulse, then a clean frame.
        do_reset();
        TX_En_Sig = 1'b1;
        TX_Data   = 8'h55;
        tick();
        TX_En_Sig = 1'b0;
        repeat (48) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_idle("midrst", 2'd0, 3'b110);
        begin
            logic seen_bad;
            seen_bad = 1'b0;
            for (int c = 0; c < 200; c++) begin
                if (w_done[0] !== 1'b0 || w_pin[0] !== 1'b1 || w_ready[0] !== 1'b1) seen_bad = 1'b1;
                tick();
            end
            n_checks++;
            if (seen_bad) begin
                n_errors++;
                $display("FAIL midrst_quiet: activity seen=%b expected %b", seen_bad, 1'b0);
            end
        end
        TX_En_Sig = 1'b1;
        TX_Data   = 8'h3C;
        tick();
        TX_En_Sig = 1'b0;
        check_frame(2'd0, 8'h3C, 1'b0, 10, 0, "midrst_resend");

        // Inputs scrambled while busy: the accepted byte is what goes out.
        do_reset();
        TX_En_Sig = 1'b1;
        TX_Data   = 8'hC5;
        tick();
        check_frame(2'd1, 8'hC5, 1'b1, 11, 1, "noise_C5");
        tick();
        check_idle("noise_after", 2'd1, 3'b110);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
